// File: rtl/codeword_serializer.sv
// codeword_serializer: takes one parallel codeword per valid/ready handshake and shifts it
// out LSB first, one bit per consumed beat, flagging the first and last beat of each frame.
// Width codes: 2'b00 = 8 bits, 2'b01 = 16, 2'b10 = 32, 2'b11 = reserved (word dropped).
// Optional feature: define CODEWORD_SERIALIZER_PARITY_EN to append an even-parity beat.
module codeword_serializer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cw_width,
    input  logic [DATA_W-1:0] cw_in,
    input  logic              cw_valid,
    output logic              cw_ready,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic              err_width
);

`ifdef CODEWORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
`ifdef CODEWORD_SERIALIZER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              accept;
    logic              reserved;
    logic              last_done;
    logic [DATA_W-1:0] load_mask;
    logic [4:0]        load_cnt;

    assign reserved  = (cw_width == 2'b11);
    assign last_done = last_q && ser_ready;
    assign cw_ready  = (state_q == StIdle) || last_done;
    assign accept    = cw_valid && cw_ready;

    assign ser_data  = shift_q[0];
    assign ser_valid = (state_q != StIdle);
    assign ser_first = first_q;
    assign ser_last  = last_q;
    assign err_width = err_q;

    // Decode the width code into a load mask and the initial bit counter value.
    always_comb begin
        load_mask = '0;
        load_cnt  = '0;
        unique case (cw_width)
            2'b00: begin
                load_mask = DATA_W'(32'h0000_00FF);
                load_cnt  = 5'd7;
            end
            2'b01: begin
                load_mask = DATA_W'(32'h0000_FFFF);
                load_cnt  = 5'd15;
            end
            2'b10: begin
                load_mask = '1;
                load_cnt  = 5'd31;
            end
            default: begin
                load_mask = '0;
                load_cnt  = '0;
            end
        endcase
    end

    // Next-state: shift on consumed beats, end/reload on the last beat, load on accept.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        last_d   = last_q;
        err_d    = 1'b0;
`ifdef CODEWORD_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
            end
            StShift: begin
                if (ser_ready && !last_q) begin
`ifdef CODEWORD_SERIALIZER_PARITY_EN
                    if (cnt_q == 5'd0) begin
                        // Data bits exhausted: present the precomputed parity beat.
                        state_d = StParity;
                        shift_d = {{(DATA_W-1){1'b0}}, parity_q};
                        first_d = 1'b0;
                        last_d  = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q - 5'd1;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                    end
`else
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q - 5'd1;
                    first_d = 1'b0;
                    last_d  = (cnt_q == 5'd1);
`endif
                end
            end
`ifdef CODEWORD_SERIALIZER_PARITY_EN
            StParity: begin
            end
`endif
            default: state_d = StIdle;
        endcase

        if (last_done) begin
            state_d = StIdle;
            shift_d = '0;
            cnt_d   = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
        end

        // Accept only happens in idle or on a consumed last beat, so it overrides the above.
        if (accept) begin
            if (reserved) begin
                err_d = 1'b1;
            end else begin
                state_d  = StShift;
                shift_d  = cw_in & load_mask;
                cnt_d    = load_cnt;
                first_d  = 1'b1;
                last_d   = 1'b0;
`ifdef CODEWORD_SERIALIZER_PARITY_EN
                parity_d = ^(cw_in & load_mask);
`endif
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef CODEWORD_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            err_q    <= err_d;
`ifdef CODEWORD_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_codeword_serializer.sv
// Bench for codeword_serializer: directed frames, expected beats queued by the stimulus and
// checked by an independent monitor on the falling clock edge.
module tb_codeword_serializer;

`ifdef CODEWORD_SERIALIZER_PARITY_EN
    localparam int ParEn = 1;
`else
    localparam int ParEn = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  cw_width;
    logic [31:0] cw_in;
    logic        cw_valid;
    logic        cw_ready;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_first;
    logic        ser_last;
    logic        err_width;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats: {data, first, last}
    logic [2:0] exp_q[$];

    codeword_serializer #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cw_width  (cw_width),
        .cw_in     (cw_in),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .err_width (err_width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_beats(input logic [31:0] cw, input int len, input int n);
        logic par;
        par = 1'b0;
        for (int i = 0; i < len; i++) par ^= cw[i];
        for (int i = 0; i < n && i < len; i++)
            exp_q.push_back({cw[i], (i == 0), (i == len - 1) && (ParEn == 0)});
        if (ParEn != 0 && n > len) exp_q.push_back({par, 1'b0, 1'b1});
    endfunction

    function automatic void push_frame(input logic [31:0] cw, input int len);
        push_beats(cw, len, len + ParEn);
    endfunction

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: compares consumed beats against the queue and checks stability under stall.
    logic       stall;
    logic [2:0] held;
    initial stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ser_valid) begin
            if (stall) chk("stall_hold", {ser_data, ser_first, ser_last}, held);
            if (ser_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    chk("beat", {ser_data, ser_first, ser_last}, e);
                end
            end
            stall = !ser_ready;
            held  = {ser_data, ser_first, ser_last};
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt, gaps, consumed, total;
        logic seen_hi, seen_lo_after, drop, rdy;

        rst_n = 1'b0; cw_valid = 1'b0; cw_width = 2'b00; cw_in = '0; ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_ser_first", ser_first, 0);
        chk("rst_ser_last", ser_last, 0);
        chk("rst_err_width", err_width, 0);
        chk("rst_cw_ready", cw_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Width 8: A5 -> 1,0,1,0,0,1,0,1 (+ parity 0)
        @(posedge clk); #1;
        ser_ready = 1'b1; cw_valid = 1'b1; cw_width = 2'b00; cw_in = 32'h0000_00A5;
        push_frame(32'h0000_00A5, 8);
        @(posedge clk); #1;
        cw_valid = 1'b0;
        @(negedge clk);
        chk("w8_latency_valid", ser_valid, 1);
        chk("w8_latency_first", ser_first, 1);
        drain("w8_drain", 40);

        // Width 16 back-to-back with cw_valid held high
        @(posedge clk); #1;
        push_frame(32'h0000_8001, 16);
        push_frame(32'h0000_0002, 16);
        cw_valid = 1'b1; cw_width = 2'b01; cw_in = 32'h0000_8001; ser_ready = 1'b1;
        @(posedge clk); #1;
        cw_in = 32'h0000_0002;
        vcnt = 0; gaps = 0; seen_hi = 1'b0; seen_lo_after = 1'b0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            drop = cw_valid && cw_ready;
            if (ser_valid) begin
                vcnt++;
                if (seen_lo_after) gaps++;
                seen_hi = 1'b1;
            end else if (seen_hi) begin
                seen_lo_after = 1'b1;
            end
            @(posedge clk); #1;
            if (drop) cw_valid = 1'b0;
        end
        chk("b2b_beats", vcnt, 32 + 2 * ParEn);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_queue", exp_q.size(), 0);

        // Width 32 with ser_ready toggling 1,0,1,0
        push_frame(32'hF000_000F, 32);
        total = 32 + ParEn;
        cw_valid = 1'b1; cw_width = 2'b10; cw_in = 32'hF000_000F; ser_ready = 1'b1;
        @(posedge clk); #1;
        cw_valid = 1'b0;
        consumed = 0; rdy = 1'b1;
        for (int c = 0; c < 120 && consumed < total; c++) begin
            ser_ready = rdy;
            @(negedge clk);
            chk("bp_cw_ready", cw_ready, (consumed == total - 1) && rdy);
            if (ser_valid && ser_ready) consumed++;
            @(posedge clk); #1;
            rdy = !rdy;
        end
        chk("bp_consumed", consumed, total);
        ser_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", ser_valid, 0);

        // Reserved width code
        @(posedge clk); #1;
        cw_valid = 1'b1; cw_width = 2'b11; cw_in = 32'h1234_5678;
        @(negedge clk);
        chk("rsv_ready_before", cw_ready, 1);
        @(posedge clk); #1;
        cw_valid = 1'b0; cw_width = 2'b00;
        @(negedge clk);
        chk("rsv_err_pulse", err_width, 1);
        chk("rsv_no_valid", ser_valid, 0);
        chk("rsv_ready", cw_ready, 1);
        @(negedge clk);
        chk("rsv_err_one_cycle", err_width, 0);
        chk("rsv_no_valid2", ser_valid, 0);

        // Reset during beat 5 of a 16-bit frame (1234 -> 0,0,1,0,1 consumed)
        @(posedge clk); #1;
        push_beats(32'h0000_1234, 16, 5);
        cw_valid = 1'b1; cw_width = 2'b01; cw_in = 32'h0000_1234; ser_ready = 1'b1;
        @(posedge clk); #1;
        cw_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        ser_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", ser_valid, 0);
        chk("mid_rst_first", ser_first, 0);
        chk("mid_rst_last", ser_last, 0);
        chk("mid_rst_ready", cw_ready, 1);
        chk("mid_rst_consumed", exp_q.size(), 0);

        @(posedge clk); #1;
        push_frame(32'h0000_003C, 8);
        cw_valid = 1'b1; cw_width = 2'b00; cw_in = 32'hFFFF_FF3C; ser_ready = 1'b1;
        @(posedge clk); #1;
        cw_valid = 1'b0;
        drain("post_rst_drain", 40);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle", ser_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codeword_serializer.md
# codeword_serializer

Serial output stage directly downstream of the encoder. Accepts one parallel codeword per valid/ready handshake, with the same 2-bit CODEWORD_WIDTH code the encoder uses, and shifts it out one bit per accepted beat, LSB first. It marks the first and last bit of each codeword. It sits between the encoder's data_out and the serial channel/link driver.

## Interface
- DATA_W, 32: maximum codeword width; cw_in width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- cw_width  input  2  CODEWORD_WIDTH code: 2'b00 = 8 bits, 2'b01 = 16, 2'b10 = 32, 2'b11 = reserved.
- cw_in  input  DATA_W  codeword from the encoder; bits above the selected width are ignored.
- cw_valid  input  1  cw_in/cw_width valid.
- cw_ready  output  1  serializer can accept a codeword this cycle.
- ser_data  output  1  current serial bit.
- ser_valid  output  1  ser_data valid.
- ser_ready  input  1  downstream consumes ser_data this cycle.
- ser_first  output  1  ser_data is bit 0 of a codeword.
- ser_last  output  1  ser_data is the final bit of the frame.
- err_width  output  1  one-cycle pulse: reserved width code accepted and dropped.

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- Accept = cw_valid && cw_ready. cw_width is latched on accept. cw_in[0 .. len-1] is loaded into the shift register, with len = 8/16/32. The bit counter is loaded with len-1.
- IDLE: cw_ready = 1, ser_valid = 0. Accept with a legal width goes to SHIFT. Accept with width 2'b11 drops the codeword, pulses err_width the next cycle and stays in IDLE.
- SHIFT: ser_valid = 1. ser_data = shift register bit 0. Each cycle with ser_ready high shifts right by one and decrements the counter. When ser_valid && !ser_ready, ser_data, ser_first and ser_last hold stable.
- ser_first is high only on the first beat of a frame. ser_last is high on beat len-1 (without parity) or on the parity beat (with parity).
- Last beat consumed (ser_last && ser_ready): go to IDLE, or reload directly if a new codeword is accepted in the same cycle.
- cw_ready = (state == IDLE) || (ser_last && ser_ready). This gives back-to-back frames with no gap beat.
- Reserved width on a back-to-back accept: the current frame ends normally, the new word is dropped, err_width pulses and the FSM goes to IDLE.
- Reset (rst_n low at a clock edge), including mid-frame: state goes to IDLE, the in-flight codeword is discarded, and the shift register and counter are cleared.

## Timing
- All outputs are registered except cw_ready, which is combinational from state, ser_last and ser_ready.
- Reset values: ser_data 0, ser_valid 0, ser_first 0, ser_last 0, err_width 0. cw_ready is 1 during and after reset (the FSM is in IDLE).
- Latency: if a codeword is accepted at edge N, its bit 0 is on ser_data with ser_valid and ser_first high after edge N.
- A frame occupies len consumed beats (len+1 with parity). Full throughput is one bit per clock when ser_ready is held high.
- err_width is high for exactly one cycle, after the accepting edge.

## Configuration
- CODEWORD_SERIALIZER_PARITY_EN defined:
  - An overall even-parity bit (XOR of the len codeword bits) is appended as an extra beat in state PARITY.
  - ser_last moves to the parity beat.
  - The parity value is computed at accept time.
- Not defined:
  - PARITY state and parity logic are absent.
  - Frame length is exactly len.

## Test plan
- Width 8: cw_width 2'b00, cw_in 32'h0000_00A5, ser_ready held 1.
  - ser_data sequence is 1,0,1,0,0,1,0,1 on consecutive cycles.
  - ser_first on beat 0, ser_last on beat 7.
  - With parity enabled: a ninth beat of 0, carrying ser_last.
- Width 16, back-to-back: 16'h8001, then 16'h0002 offered with cw_valid held high.
  - Second frame's ser_first appears on the cycle immediately after the first frame's ser_last beat.
  - The two frames total 32 consecutive ser_valid beats.
- Width 32, backpressure: cw_in 32'hF000_000F, ser_ready toggling 1,0,1,0.
  - Each bit holds through stall cycles; 32 beats are consumed.
  - cw_ready stays 0 until the last beat is consumed.
- Reserved width: cw_width 2'b11 with cw_valid high.
  - err_width is a single-cycle pulse; ser_valid stays 0; cw_ready remains 1.
- Reset mid-frame: rst_n low for 1 cycle during beat 5 of a 16-bit frame.
  - Next cycle: ser_valid 0, ser_first/ser_last 0, cw_ready 1.
  - A new 8-bit codeword is then serialized correctly from bit 0.
